// File: rtl/bit_alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit bit_alu: latches one WIDTH-bit operation,
// steps the ALU LSB first, one bit per cycle, and hands back the assembled word.
module bit_alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [1:0]       alu_sel,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_y
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            opa_q    <= opa;
            opb_q    <= opb;
            result_q <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // alu_y reflects the bit currently being driven, so capture it in place
          result_q[cnt_q] <= alu_y;
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // ALU inputs are forced to zero whenever no bit is being processed
  assign alu_sel = (state_q == RUN) ? op_q : 2'b00;
  assign alu_a   = (state_q == RUN) & opa_q[cnt_q];
  assign alu_b   = (state_q == RUN) & opb_q[cnt_q];

endmodule
